// File: rtl/midside_axis_xform.sv
// -----------------------------------------------------------------------------
// midside_axis_xform
//
// Streaming stereo mid/side transform controlled through one AXI4-Lite register.
// Each stream beat carries two signed channels: ch0 in tdata[2*DATA_W-1:DATA_W]
// and ch1 in tdata[DATA_W-1:0]. The MODE field of CTRL (address 0x0, bits [1:0])
// selects the operation:
//   0 / 3 : bypass  out = {a, b}
//   1     : encode  M = (a+b)>>>1, S = (a-b)>>>1   (floor rounding)
//   2     : decode  L = sat(a+b),  R = sat(a-b)
// Latency is two accepted clocks. Both stages advance only while m_axis_tready
// is high, and s_axis_tready mirrors m_axis_tready.
//
// Ports
//   aclk, areset          clock, asynchronous active-high reset
//   s_axi_aw*/w*/b*       AXI4-Lite write channels (single register, OKAY only)
//   s_axi_ar*/r*          AXI4-Lite read channels
//   s_axis_*              input sample stream  {ch0, ch1}, tlast
//   m_axis_*              output sample stream {ch0, ch1}, tlast delayed
// -----------------------------------------------------------------------------
module midside_axis_xform #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic                  aclk,
  input  logic                  areset,
  // AXI4-Lite write address / data / response
  input  logic [ADDR_W-1:0]     s_axi_awaddr,
  input  logic [2:0]            s_axi_awprot,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [31:0]           s_axi_wdata,
  input  logic [3:0]            s_axi_wstrb,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  // AXI4-Lite read address / data
  input  logic [ADDR_W-1:0]     s_axi_araddr,
  input  logic [2:0]            s_axi_arprot,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [31:0]           s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  // AXI-Stream input
  input  logic [2*DATA_W-1:0]   s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  // AXI-Stream output
  output logic [2*DATA_W-1:0]   m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast
);

  localparam logic [1:0] MODE_ENC = 2'd1;
  localparam logic [1:0] MODE_DEC = 2'd2;

  localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  // ---------------------------------------------------------------------------
  // Control register and AXI4-Lite slave
  // ---------------------------------------------------------------------------
  logic [1:0]  mode_reg;
  logic        aw_hs_reg;
  logic        bvalid_reg;
  logic        ar_hs_reg;
  logic        rvalid_reg;
  logic [31:0] rdata_reg;

  logic wr_fire;
  logic rd_fire;
  logic wr_sel_ctrl;
  logic rd_sel_ctrl;

  // The ready pulse is only raised once both beats are present, so the
  // handshake completes on the clock that ends the pulse.
  assign wr_fire     = aw_hs_reg & s_axi_awvalid & s_axi_wvalid;
  assign rd_fire     = ar_hs_reg & s_axi_arvalid;
  assign wr_sel_ctrl = (s_axi_awaddr[ADDR_W-1:2] == '0);
  assign rd_sel_ctrl = (s_axi_araddr[ADDR_W-1:2] == '0);

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      mode_reg   <= 2'd0;
      aw_hs_reg  <= 1'b0;
      bvalid_reg <= 1'b0;
    end else begin
      // ~aw_hs_reg keeps the ready a single-cycle pulse per transaction
      aw_hs_reg <= s_axi_awvalid & s_axi_wvalid & ~bvalid_reg & ~aw_hs_reg;
      if (wr_fire) begin
        bvalid_reg <= 1'b1;
        if (wr_sel_ctrl && s_axi_wstrb[0]) begin
          mode_reg <= s_axi_wdata[1:0];
        end
      end else if (bvalid_reg && s_axi_bready) begin
        bvalid_reg <= 1'b0;
      end
    end
  end

  // Reads sample mode_reg before any same-edge write lands, so a colliding
  // read returns the old value.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      ar_hs_reg  <= 1'b0;
      rvalid_reg <= 1'b0;
      rdata_reg  <= 32'd0;
    end else begin
      ar_hs_reg <= s_axi_arvalid & ~rvalid_reg & ~ar_hs_reg;
      if (rd_fire) begin
        rvalid_reg <= 1'b1;
        rdata_reg  <= rd_sel_ctrl ? {30'd0, mode_reg} : 32'd0;
      end else if (rvalid_reg && s_axi_rready) begin
        rvalid_reg <= 1'b0;
      end
    end
  end

  assign s_axi_awready = aw_hs_reg;
  assign s_axi_wready  = aw_hs_reg;
  assign s_axi_bvalid  = bvalid_reg;
  assign s_axi_bresp   = 2'b00;
  assign s_axi_arready = ar_hs_reg;
  assign s_axi_rvalid  = rvalid_reg;
  assign s_axi_rdata   = rdata_reg;
  assign s_axi_rresp   = 2'b00;

  // ---------------------------------------------------------------------------
  // Stream pipeline
  // ---------------------------------------------------------------------------
  logic en;
  assign en            = m_axis_tready;
  assign s_axis_tready = m_axis_tready;

  logic [2*DATA_W-1:0] s1_data_reg;
  logic                s1_last_reg;
  logic                s1_valid_reg;
  logic [1:0]          s1_mode_reg;

  // Stage 1: capture the beat together with the mode it must be processed in
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      s1_data_reg  <= '0;
      s1_last_reg  <= 1'b0;
      s1_valid_reg <= 1'b0;
      s1_mode_reg  <= 2'd0;
    end else if (en) begin
      s1_data_reg  <= s_axis_tdata;
      s1_last_reg  <= s_axis_tlast;
      s1_valid_reg <= s_axis_tvalid;
      s1_mode_reg  <= mode_reg;
    end
  end

  // Sign-extended operands; the DATA_W+1 bit sum/difference cannot overflow.
  logic [DATA_W:0] a_ext;
  logic [DATA_W:0] b_ext;
  assign a_ext = {s1_data_reg[2*DATA_W-1], s1_data_reg[2*DATA_W-1:DATA_W]};
  assign b_ext = {s1_data_reg[DATA_W-1],   s1_data_reg[DATA_W-1:0]};

  // Channel 0 works on a+b, channel 1 on a-b; everything else is shared.
  logic [1:0][DATA_W-1:0] res_ch;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_ch
      logic [DATA_W:0]   wide;
      logic [DATA_W-1:0] enc_val;
      logic [DATA_W-1:0] dec_val;
      logic [DATA_W-1:0] byp_val;

      if (gi == 0) begin : g_sum
        assign wide    = a_ext + b_ext;
        assign byp_val = a_ext[DATA_W-1:0];
      end else begin : g_diff
        assign wide    = a_ext - b_ext;
        assign byp_val = b_ext[DATA_W-1:0];
      end

      // Dropping the LSB of the wide result is an arithmetic shift right
      // with floor rounding, and always fits back in DATA_W bits.
      assign enc_val = wide[DATA_W:1];

      // Overflow whenever the two top bits disagree; clamp by sign.
      assign dec_val = (wide[DATA_W] != wide[DATA_W-1]) ?
                       (wide[DATA_W] ? SAT_MIN : SAT_MAX) :
                       wide[DATA_W-1:0];

      always_comb begin
        res_ch[gi] = byp_val;
        case (s1_mode_reg)
          MODE_ENC: res_ch[gi] = enc_val;
          MODE_DEC: res_ch[gi] = dec_val;
          default:  res_ch[gi] = byp_val;
        endcase
      end
    end
  endgenerate

  // Stage 2: registered outputs
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tvalid <= 1'b0;
    end else if (en) begin
      m_axis_tdata  <= {res_ch[0], res_ch[1]};
      m_axis_tlast  <= s1_last_reg;
      m_axis_tvalid <= s1_valid_reg;
    end
  end

  // Inputs that carry no information for this single-register slave.
  logic unused_ok;
  assign unused_ok = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0],
                       s_axi_araddr[1:0], s_axi_wdata[31:2], s_axi_wstrb[3:1]};

endmodule

// File: tb/tb_midside_axis_xform.sv
// -----------------------------------------------------------------------------
// tb_midside_axis_xform
//
// Directed self-checking bench for midside_axis_xform: reset state, bypass,
// encode, decode with saturation, register access, backpressure, and an
// asynchronous reset in the middle of a stream.
// -----------------------------------------------------------------------------
module tb_midside_axis_xform;

  logic        aclk;
  logic        areset;
  logic [3:0]  s_axi_awaddr;
  logic [2:0]  s_axi_awprot;
  logic        s_axi_awvalid;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_wvalid;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready;
  logic [3:0]  s_axi_araddr;
  logic [2:0]  s_axi_arprot;
  logic        s_axi_arvalid;
  logic        s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid;
  logic        s_axi_rready;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic        s_axis_tlast;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;

  int n_cmp = 0;
  int n_err = 0;

  midside_axis_xform #(.DATA_W(16), .ADDR_W(4)) dut (
    .aclk          (aclk),
    .areset        (areset),
    .s_axi_awaddr  (s_axi_awaddr),
    .s_axi_awprot  (s_axi_awprot),
    .s_axi_awvalid (s_axi_awvalid),
    .s_axi_awready (s_axi_awready),
    .s_axi_wdata   (s_axi_wdata),
    .s_axi_wstrb   (s_axi_wstrb),
    .s_axi_wvalid  (s_axi_wvalid),
    .s_axi_wready  (s_axi_wready),
    .s_axi_bresp   (s_axi_bresp),
    .s_axi_bvalid  (s_axi_bvalid),
    .s_axi_bready  (s_axi_bready),
    .s_axi_araddr  (s_axi_araddr),
    .s_axi_arprot  (s_axi_arprot),
    .s_axi_arvalid (s_axi_arvalid),
    .s_axi_arready (s_axi_arready),
    .s_axi_rdata   (s_axi_rdata),
    .s_axi_rresp   (s_axi_rresp),
    .s_axi_rvalid  (s_axi_rvalid),
    .s_axi_rready  (s_axi_rready),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic axi_wr(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
    logic ok;
    s_axi_awaddr  = addr;
    s_axi_awvalid = 1'b1;
    s_axi_wdata   = data;
    s_axi_wstrb   = strb;
    s_axi_wvalid  = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      tick();
      if (s_axi_awready && s_axi_wready) ok = 1'b1;
    end
    chk("wr_ready", {31'd0, ok}, 32'd1);
    tick();
    s_axi_awvalid = 1'b0;
    s_axi_wvalid  = 1'b0;
    chk("bvalid_set", {31'd0, s_axi_bvalid}, 32'd1);
    chk("bresp", {30'd0, s_axi_bresp}, 32'd0);
    s_axi_bready = 1'b1;
    tick();
    s_axi_bready = 1'b0;
    chk("bvalid_clr", {31'd0, s_axi_bvalid}, 32'd0);
  endtask

  task automatic axi_rd(input logic [3:0] addr, output logic [31:0] data);
    logic ok;
    s_axi_araddr  = addr;
    s_axi_arvalid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      tick();
      if (s_axi_arready) ok = 1'b1;
    end
    chk("rd_ready", {31'd0, ok}, 32'd1);
    tick();
    s_axi_arvalid = 1'b0;
    chk("rvalid_set", {31'd0, s_axi_rvalid}, 32'd1);
    chk("rresp", {30'd0, s_axi_rresp}, 32'd0);
    data = s_axi_rdata;
    s_axi_rready = 1'b1;
    tick();
    s_axi_rready = 1'b0;
    chk("rvalid_clr", {31'd0, s_axi_rvalid}, 32'd0);
  endtask

  // One beat into an empty pipeline: no output after the first clock,
  // the result exactly after the second.
  task automatic send_chk(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] ea, input logic [15:0] eb);
    s_axis_tdata  = {a, b};
    s_axis_tlast  = 1'b1;
    s_axis_tvalid = 1'b1;
    tick();
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    chk({tag, "_lat1"}, {31'd0, m_axis_tvalid}, 32'd0);
    tick();
    chk({tag, "_valid"}, {31'd0, m_axis_tvalid}, 32'd1);
    chk({tag, "_data"}, m_axis_tdata, {ea, eb});
    chk({tag, "_last"}, {31'd0, m_axis_tlast}, 32'd1);
  endtask

  logic [31:0] rd;
  logic [31:0] bp_data [8];
  logic [31:0] bp_ready;
  logic [31:0] prev_data;
  logic        prev_last;
  logic        held;
  logic        accepted;
  int          in_i;
  int          out_i;

  initial begin
    areset        = 1'b1;
    s_axi_awaddr  = '0;
    s_axi_awprot  = '0;
    s_axi_awvalid = 1'b0;
    s_axi_wdata   = '0;
    s_axi_wstrb   = '0;
    s_axi_wvalid  = 1'b0;
    s_axi_bready  = 1'b0;
    s_axi_araddr  = '0;
    s_axi_arprot  = '0;
    s_axi_arvalid = 1'b0;
    s_axi_rready  = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    m_axis_tready = 1'b0;

    // ---- reset state ----
    tick();
    tick();
    chk("rst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    chk("rst_tdata", m_axis_tdata, 32'd0);
    chk("rst_tlast", {31'd0, m_axis_tlast}, 32'd0);
    chk("rst_bvalid", {31'd0, s_axi_bvalid}, 32'd0);
    chk("rst_rvalid", {31'd0, s_axi_rvalid}, 32'd0);
    chk("rst_awready", {31'd0, s_axi_awready}, 32'd0);
    chk("rst_arready", {31'd0, s_axi_arready}, 32'd0);
    chk("tready_lo", {31'd0, s_axis_tready}, 32'd0);
    m_axis_tready = 1'b1;
    #1;
    chk("tready_hi", {31'd0, s_axis_tready}, 32'd1);
    areset = 1'b0;
    tick();

    // ---- bypass ----
    send_chk("byp0", 16'd1000, 16'd500, 16'd1000, 16'd500);
    send_chk("byp1", -16'sd500, 16'd250, -16'sd500, 16'd250);

    // ---- encode ----
    axi_wr(4'h0, 32'h1, 4'hF);
    send_chk("enc0", 16'd2000, 16'd1000, 16'd1500, 16'd500);
    send_chk("enc1", -16'sd2000, 16'd2000, 16'd0, -16'sd2000);
    send_chk("enc2", 16'd3, 16'd0, 16'd1, 16'd1);
    send_chk("enc3", -16'sd3, 16'd0, -16'sd2, -16'sd2);

    // ---- decode ----
    axi_wr(4'h0, 32'h2, 4'hF);
    send_chk("dec0", 16'd1500, 16'd500, 16'd2000, 16'd1000);
    send_chk("dec1", 16'd0, -16'sd2000, -16'sd2000, 16'd2000);
    send_chk("dec_satp", 16'sd32767, 16'sd32767, 16'sd32767, 16'd0);
    send_chk("dec_satn", 16'h8000, 16'sd32767, 16'hFFFF, 16'h8000);

    // ---- register access ----
    axi_rd(4'h0, rd);
    chk("rd_ctrl2", rd, 32'h2);
    axi_wr(4'h0, 32'h3, 4'hF);
    axi_rd(4'h0, rd);
    chk("rd_ctrl3", rd, 32'h3);
    send_chk("byp3", 16'd1234, -16'sd1234, 16'd1234, -16'sd1234);
    axi_wr(4'h0, 32'h1, 4'h0);
    axi_rd(4'h0, rd);
    chk("rd_nostrb", rd, 32'h3);
    axi_wr(4'h8, 32'h2, 4'hF);
    axi_rd(4'h0, rd);
    chk("rd_other_wr", rd, 32'h3);
    axi_rd(4'h8, rd);
    chk("rd_0x8", rd, 32'h0);

    // ---- backpressure, mode 3 (bypass) ----
    bp_data[0] = 32'h0001_0002;
    bp_data[1] = 32'h0003_0004;
    bp_data[2] = 32'hFFFF_8000;
    bp_data[3] = 32'h1234_5678;
    bp_data[4] = 32'h7FFF_0001;
    bp_data[5] = 32'h00AA_0055;
    bp_data[6] = 32'hDEAD_BEEF;
    bp_data[7] = 32'h0F0F_F0F0;
    bp_ready   = 32'b1111_1011_0010_1101_1001_1011_0100_1101;
    in_i  = 0;
    out_i = 0;
    held  = 1'b0;
    prev_data = '0;
    prev_last = 1'b0;
    for (int c = 0; c < 60 && out_i < 8; c++) begin
      m_axis_tready = bp_ready[c % 32];
      if (held) begin
        chk("bp_hold_valid", {31'd0, m_axis_tvalid}, 32'd1);
        chk("bp_hold_data", m_axis_tdata, prev_data);
        chk("bp_hold_last", {31'd0, m_axis_tlast}, {31'd0, prev_last});
      end
      if (in_i < 8) begin
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = bp_data[in_i];
        s_axis_tlast  = (in_i == 3) || (in_i == 7);
      end else begin
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
      end
      if (m_axis_tvalid && m_axis_tready) begin
        chk("bp_data", m_axis_tdata, bp_data[out_i]);
        chk("bp_last", {31'd0, m_axis_tlast}, ((out_i == 3) || (out_i == 7)) ? 32'd1 : 32'd0);
        out_i++;
      end
      held      = m_axis_tvalid && !m_axis_tready;
      prev_data = m_axis_tdata;
      prev_last = m_axis_tlast;
      accepted  = s_axis_tvalid && m_axis_tready;
      tick();
      if (accepted) in_i++;
    end
    chk("bp_count", out_i, 32'd8);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    m_axis_tready = 1'b1;
    chk("bp_no_dup", {31'd0, m_axis_tvalid}, 32'd0);
    tick();
    tick();

    // ---- asynchronous reset mid-stream ----
    axi_wr(4'h0, 32'h1, 4'hF);
    s_axis_tdata  = {-16'sd3, 16'd0};
    s_axis_tvalid = 1'b1;
    tick();
    s_axis_tvalid = 1'b0;
    tick();
    chk("pre_rst_valid", {31'd0, m_axis_tvalid}, 32'd1);
    chk("pre_rst_data", m_axis_tdata, 32'hFFFE_FFFE);
    #2;
    areset = 1'b1;
    #1;
    chk("arst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    chk("arst_tdata", m_axis_tdata, 32'd0);
    tick();
    areset = 1'b0;
    tick();
    axi_rd(4'h0, rd);
    chk("rd_after_rst", rd, 32'h0);
    send_chk("byp_rst", 16'd2000, 16'd1000, 16'd2000, 16'd1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/midside_axis_xform.md
Name: midside_axis_xform

Overview:
Streaming stereo mid/side transform with an AXI4-Lite control register. It sits in the audio datapath between AXI-Stream stages. Each stereo sample carries L in tdata[31:16] and R in tdata[15:0]. A run-time mode selects bypass, encode (L/R to M/S) or decode (M/S to L/R), with a fixed 2-cycle latency.

Parameters:
DATA_W, 16, signed sample width per channel; tdata width is 2*DATA_W.
ADDR_W, 4, AXI-Lite address width.

Ports:
aclk  in  1  clock
areset  in  1  reset
s_axi_awaddr  in  ADDR_W  write address
s_axi_awprot  in  3  ignored
s_axi_awvalid/s_axi_awready  in/out  1  write-address handshake
s_axi_wdata  in  32  write data
s_axi_wstrb  in  4  byte strobes
s_axi_wvalid/s_axi_wready  in/out  1  write-data handshake
s_axi_bresp  out  2  always 2'b00 (OKAY)
s_axi_bvalid/s_axi_bready  out/in  1  write response
s_axi_araddr  in  ADDR_W  read address
s_axi_arprot  in  3  ignored
s_axi_arvalid/s_axi_arready  in/out  1  read-address handshake
s_axi_rdata  out  32  read data
s_axi_rresp  out  2  always 2'b00
s_axi_rvalid/s_axi_rready  out/in  1  read data
s_axis_tdata  in  2*DATA_W  {ch0, ch1}
s_axis_tvalid/s_axis_tready  in/out  1  input handshake
s_axis_tlast  in  1  frame marker
m_axis_tdata  out  2*DATA_W  {ch0, ch1}
m_axis_tvalid/m_axis_tready  out/in  1  output handshake
m_axis_tlast  out  1  delayed s_axis_tlast

Behaviour:
- Interface timing: one clock; reset is asynchronous and active-high.
- Reset values:
  - All outputs 0, except s_axis_tready = m_axis_tready.
  - CTRL = 0 (bypass); pipeline valid bits cleared.
- Register map:
  - 0x0 CTRL, read/write. Bits [1:0] = MODE; other bits read 0.
  - MODE 0 = bypass, 1 = encode, 2 = decode, 3 = treated as bypass.
  - Other addresses read 0; writes to them are ignored; response is still OKAY.
  - Only wstrb[0] gates the MODE update.
- AXI-Lite write:
  - When awvalid and wvalid are both high and bvalid is low, awready and wready pulse high for one cycle together and the register updates.
  - bvalid rises the next cycle and holds until bready.
  - An address or data beat arriving alone waits for its partner.
- AXI-Lite read:
  - When arvalid is high and rvalid is low, arready pulses for one cycle.
  - rdata/rvalid are registered the next cycle; rvalid holds until rready.
- Stream pipeline:
  - Two register stages with a global enable `en = m_axis_tready`; s_axis_tready = m_axis_tready.
  - Stage 1 captures tdata, tlast, valid (= s_axis_tvalid) and the current MODE.
  - Stage 2 computes the result from stage 1. Outputs are registered.
  - Latency is exactly 2 accepted-clock cycles from an input beat to m_axis_tvalid.
  - When en is low, all stages hold and the output stays stable.
- Mode sampling: the mode is latched per sample at stage 1, so a CTRL write mid-stream affects only samples accepted afterwards.
- Arithmetic (signed DATA_W inputs a = ch0, b = ch1, DATA_W+1-bit intermediates):
  - Bypass: out = {a, b}.
  - Encode: M = (a+b)>>>1, S = (a-b)>>>1. Arithmetic shift, floor rounding; no overflow possible.
  - Decode: L = a+b, R = a-b, each saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- Boundary cases:
  - Back-to-back beats run at full throughput.
  - Bubbles propagate as tvalid=0.
  - Reset mid-stream flushes the pipeline immediately (asynchronously).
  - Simultaneous AXI-Lite read and write are served independently.
  - A read returns the pre-write value if it is sampled in the same cycle as a write.

Test Plan:
- Reset, bypass: send (1000,500) then (-500,250) -> outputs (1000,500) and (-500,250), each tvalid exactly 2 cycles after its input handshake.
- Write CTRL=1: send (2000,1000) -> (1500,500). Send (-2000,2000) -> (0,-2000). Send (3,0) -> (1,1). Send (-3,0) -> (-2,-2).
- Write CTRL=2: send (1500,500) -> (2000,1000). Send (0,-2000) -> (-2000,2000). Send (32767,32767) -> (32767,0) saturated. Send (-32768,32767) -> (-1,-32768) saturated.
- Register access: write 0x0 = 0x3, read back -> 0x3, stream in bypass. Write 0x0 = 0x1 with wstrb=0 -> readback unchanged. Read 0x8 -> 0. bresp/rresp = 0.
- Backpressure: stream 8 consecutive samples while toggling m_axis_tready -> no loss or duplication, order preserved, data held stable while tready is low, tlast aligned with its sample.
- Assert areset mid-stream -> m_axis_tvalid drops immediately, CTRL returns to 0, the next sample is bypassed.
